// File: rtl/execute_pipe.sv
// Purpose : registered execute stage - ALU, branch/jump resolution, redirect target, optional iterative MUL.
// Latency : 1 cycle for ALU/branch ops; WIDTH+1 cycles for MUL (only with EXECUTE_PIPE_MUL_EN defined).
// Backpr. : o_in_ready drops while a result is held unconsumed or a MUL is running; held outputs stay stable.
//
// Configuration macro: EXECUTE_PIPE_MUL_EN
//   defined   -> ALUOp 4'b1111 runs a WIDTH-iteration shift-add multiply (MUL state + down-counter)
//   undefined -> ALUOp 4'b1111 is illegal (ALURes=0, err=1, single cycle); FSM never leaves IDLE
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_in_valid/o_in_ready   operand bundle handshake from decode
//   i_readdata1/2, i_immediate, i_PC, i_nextPC   operands, current PC, fall-through PC
//   i_ALUOp, i_BranchOp     operation and branch-condition select
//   i_ALUSrc, i_invSrc1, i_invSrc2, i_sub, i_jump, i_jumpReg, i_branch   control bits
//   i_flush                 squash in-flight MUL and held result, drop any offered bundle
//   o_out_valid/i_out_ready result handshake to memory stage
//   o_ALURes, o_targetPC, o_redirect, o_err   registered results

module execute_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_readdata1,
  input  logic [WIDTH-1:0] i_readdata2,
  input  logic [WIDTH-1:0] i_immediate,
  input  logic [WIDTH-1:0] i_PC,
  input  logic [WIDTH-1:0] i_nextPC,
  input  logic [3:0]       i_ALUOp,
  input  logic [1:0]       i_BranchOp,
  input  logic             i_ALUSrc,
  input  logic             i_invSrc1,
  input  logic             i_invSrc2,
  input  logic             i_sub,
  input  logic             i_jump,
  input  logic             i_jumpReg,
  input  logic             i_branch,
  input  logic             i_flush,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_ALURes,
  output logic [WIDTH-1:0] o_targetPC,
  output logic             o_redirect,
  output logic             o_err
);

  // Width of the rotate complement shift amount (must be able to hold WIDTH itself).
  localparam int SW = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Output register
  logic             r_out_valid;
  logic [WIDTH-1:0] r_alu_res;
  logic [WIDTH-1:0] r_target;
  logic             r_redirect;
  logic             r_err;

  // Operand conditioning
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_bp;
  logic [WIDTH-1:0] w_sum;
  logic             w_add_ovf;
  logic [3:0]       w_sh;
  logic [SW-1:0]    w_rsh;
  logic [WIDTH-1:0] w_rol;

  // ALU and control-transfer results for single-cycle ops
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_err;
  logic             w_redirect;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_tgt_sum;
  logic             w_tgt_ovf;
  logic [WIDTH-1:0] w_target;
  logic             w_err;

  // Handshake / sequencing
  logic             w_accept;
  logic             w_alu_load;
  logic             w_mul_start;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_sum;
  logic             w_mul_redirect;
  logic [WIDTH-1:0] w_mul_target;
  logic             w_mul_err;

  // Branch condition evaluated on an ALU (or multiplier) result.
  function automatic logic f_cond(input logic [WIDTH-1:0] res, input logic [1:0] bop);
    logic c;
    case (bop)
      2'b00:   c = (res == '0);
      2'b01:   c = (res != '0);
      2'b10:   c = res[WIDTH-1];
      default: c = ~res[WIDTH-1];
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Operand path
  // ---------------------------------------------------------------------------
  assign w_a   = i_invSrc1 ? ~i_readdata1 : i_readdata1;
  assign w_b   = i_ALUSrc ? i_readdata2 : i_immediate;
  assign w_bp  = i_invSrc2 ? ~w_b : w_b;
  assign w_sum = w_a + w_bp + WIDTH'(i_sub);

  // Signed overflow: operands agree in sign but the sum does not.
  assign w_add_ovf = (w_a[WIDTH-1] == w_bp[WIDTH-1]) & (w_sum[WIDTH-1] != w_a[WIDTH-1]);

  assign w_sh  = w_bp[3:0];
  // Rotate = left shift OR'd with the bits that fall off the top; a zero
  // amount makes the right shift equal WIDTH, which yields zero.
  assign w_rsh = SW'(WIDTH) - SW'(w_sh);
  assign w_rol = (w_a << w_sh) | (w_a >> w_rsh);

  always_comb begin
    w_alu_res = '0;
    w_alu_err = 1'b0;
    case (i_ALUOp)
      4'b0000: w_alu_res = w_sum;
      4'b0001: w_alu_res = w_a & w_bp;
      4'b0010: w_alu_res = w_a | w_bp;
      4'b0011: w_alu_res = w_a ^ w_bp;
      4'b0100: w_alu_res = w_a << w_sh;
      4'b0101: w_alu_res = w_a >> w_sh;
      4'b0110: w_alu_res = $signed(w_a) >>> w_sh;
      4'b0111: w_alu_res = w_rol;
      4'b1000: begin
        w_alu_res = w_sum;
        w_alu_err = w_add_ovf;
      end
`ifdef EXECUTE_PIPE_MUL_EN
      // MUL result comes from the iterative datapath; never flags err.
      4'b1111: begin
        w_alu_res = '0;
        w_alu_err = 1'b0;
      end
`endif
      default: begin
        w_alu_res = '0;
        w_alu_err = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Branch / jump resolution
  // ---------------------------------------------------------------------------
  assign w_redirect = i_jump | i_jumpReg | (i_branch & f_cond(w_alu_res, i_BranchOp));
  assign w_base     = i_jumpReg ? i_readdata1 : i_PC;
  assign w_tgt_sum  = w_base + i_immediate;
  assign w_tgt_ovf  = (w_base[WIDTH-1] == i_immediate[WIDTH-1]) &
                      (w_tgt_sum[WIDTH-1] != w_base[WIDTH-1]);
  assign w_target   = w_redirect ? w_tgt_sum : i_nextPC;
  // Target overflow only matters when the target is actually used.
  assign w_err      = w_alu_err | (w_redirect & w_tgt_ovf);

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign o_in_ready = (r_state == S_IDLE) & (~r_out_valid | i_out_ready);
  // in_ready may read 1 during a flush, but the bundle is dropped.
  assign w_accept   = i_in_valid & o_in_ready & ~i_flush;
  assign w_alu_load = w_accept & ~w_mul_start;

  // ---------------------------------------------------------------------------
  // Iterative multiplier
  // ---------------------------------------------------------------------------
`ifdef EXECUTE_PIPE_MUL_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mc;       // multiplicand, shifted left each step
  logic [WIDTH-1:0] r_mp;       // multiplier, shifted right each step
  logic [WIDTH-1:0] r_m_tgt;    // taken target computed at acceptance
  logic [WIDTH-1:0] r_m_nextpc;
  logic             r_m_tgt_ovf;
  logic             r_m_jmp;
  logic             r_m_branch;
  logic [1:0]       r_m_bop;
  logic [WIDTH-1:0] w_mul_add;

  assign w_mul_start = w_accept & (i_ALUOp == 4'b1111);
  // Last iteration happens on the edge where the counter reads zero; its sum
  // goes straight into the output register.
  assign w_mul_done  = (r_state == S_MUL) & (r_cnt == '0) & ~i_flush;
  assign w_mul_add   = r_mp[0] ? r_mc : '0;
  assign w_mul_sum   = r_acc + w_mul_add;

  // The branch condition depends on the product, so it is resolved at completion.
  assign w_mul_redirect = r_m_jmp | (r_m_branch & f_cond(w_mul_sum, r_m_bop));
  assign w_mul_target   = w_mul_redirect ? r_m_tgt : r_m_nextpc;
  assign w_mul_err      = w_mul_redirect & r_m_tgt_ovf;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mc        <= '0;
      r_mp        <= '0;
      r_m_tgt     <= '0;
      r_m_nextpc  <= '0;
      r_m_tgt_ovf <= 1'b0;
      r_m_jmp     <= 1'b0;
      r_m_branch  <= 1'b0;
      r_m_bop     <= '0;
    end else if (i_flush) begin
      r_cnt <= '0;
    end else if (w_mul_start) begin
      r_cnt       <= CW'(WIDTH - 1);
      r_acc       <= '0;
      r_mc        <= i_readdata1;
      r_mp        <= w_b;
      r_m_tgt     <= w_tgt_sum;
      r_m_nextpc  <= i_nextPC;
      r_m_tgt_ovf <= w_tgt_ovf;
      r_m_jmp     <= i_jump | i_jumpReg;
      r_m_branch  <= i_branch;
      r_m_bop     <= i_BranchOp;
    end else if (r_state == S_MUL) begin
      r_acc <= w_mul_sum;
      r_mc  <= r_mc << 1;
      r_mp  <= r_mp >> 1;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end
`else
  assign w_mul_start    = 1'b0;
  assign w_mul_done     = 1'b0;
  assign w_mul_sum      = '0;
  assign w_mul_redirect = 1'b0;
  assign w_mul_target   = '0;
  assign w_mul_err      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_mul_start) w_state_nxt = S_MUL;
      S_MUL:   if (w_mul_done)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_alu_res   <= '0;
      r_target    <= '0;
      r_redirect  <= 1'b0;
      r_err       <= 1'b0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
    end else if (w_alu_load) begin
      // Covers the simultaneous drain-and-accept case: valid stays high.
      r_out_valid <= 1'b1;
      r_alu_res   <= w_alu_res;
      r_target    <= w_target;
      r_redirect  <= w_redirect;
      r_err       <= w_err;
    end else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_alu_res   <= w_mul_sum;
      r_target    <= w_mul_target;
      r_redirect  <= w_mul_redirect;
      r_err       <= w_mul_err;
    end else if (r_out_valid & i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_ALURes    = r_alu_res;
  assign o_targetPC  = r_target;
  assign o_redirect  = r_redirect;
  assign o_err       = r_err;

endmodule

// File: tb/tb_execute_pipe.sv
module tb_execute_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] readdata1, readdata2, immediate, PC, nextPC;
  logic [3:0]  ALUOp;
  logic [1:0]  BranchOp;
  logic        ALUSrc, invSrc1, invSrc2, sub, jump, jumpReg, branch, flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] ALURes, targetPC;
  logic        redirect, err;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] tgt;
    logic        rd;
    logic        e;
  } exp_t;

  exp_t q[$];
  int   n_checks;
  int   n_errors;
  logic accepted;

  execute_pipe #(.WIDTH(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_readdata1 (readdata1),
    .i_readdata2 (readdata2),
    .i_immediate (immediate),
    .i_PC        (PC),
    .i_nextPC    (nextPC),
    .i_ALUOp     (ALUOp),
    .i_BranchOp  (BranchOp),
    .i_ALUSrc    (ALUSrc),
    .i_invSrc1   (invSrc1),
    .i_invSrc2   (invSrc2),
    .i_sub       (sub),
    .i_jump      (jump),
    .i_jumpReg   (jumpReg),
    .i_branch    (branch),
    .i_flush     (flush),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_ALURes    (ALURes),
    .o_targetPC  (targetPC),
    .o_redirect  (redirect),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of one bundle, evaluated from the currently driven inputs.
  function automatic exp_t model();
    exp_t        x;
    logic [15:0] a, b, bp, r, base;
    logic [31:0] prod;
    logic        e, c, rd;
    int          sa, sb, ss, st, n;
    a  = invSrc1 ? ~readdata1 : readdata1;
    b  = ALUSrc ? readdata2 : immediate;
    bp = invSrc2 ? ~b : b;
    n  = int'(bp[3:0]);
    r  = 16'h0000;
    e  = 1'b0;
    prod = 32'd0;
    case (ALUOp)
      4'h0: r = a + bp + {15'd0, sub};
      4'h1: r = a & bp;
      4'h2: r = a | bp;
      4'h3: r = a ^ bp;
      4'h4: r = a << bp[3:0];
      4'h5: r = a >> bp[3:0];
      4'h6: begin r = a; for (int i = 0; i < n; i++) r = {r[15], r[15:1]}; end
      4'h7: begin r = a; for (int i = 0; i < n; i++) r = {r[14:0], r[15]}; end
      4'h8: begin
        sa = $signed(a);
        sb = $signed(bp);
        ss = sa + sb + int'(sub);
        r  = ss[15:0];
        e  = (ss > 32767) || (ss < -32768);
      end
      4'hF: begin
`ifdef EXECUTE_PIPE_MUL_EN
        prod = {16'd0, readdata1} * {16'd0, b};
        r    = prod[15:0];
`else
        e = 1'b1;
`endif
      end
      default: e = 1'b1;
    endcase
    case (BranchOp)
      2'd0:    c = (r == 16'h0000);
      2'd1:    c = (r != 16'h0000);
      2'd2:    c = r[15];
      default: c = !r[15];
    endcase
    rd   = jump || jumpReg || (branch && c);
    base = jumpReg ? readdata1 : PC;
    st   = int'($signed(base)) + int'($signed(immediate));
    if (rd && ((st > 32767) || (st < -32768))) e = 1'b1;
    x.res = r;
    x.tgt = rd ? st[15:0] : nextPC;
    x.rd  = rd;
    x.e   = e;
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: scoreboard bookkeeping at the falling edge, inputs change 1 after rising edge.
  task automatic tick();
    exp_t x;
    @(negedge clk);
    accepted = 1'b0;
    if (flush) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_checks++;
        assert (q.size() > 0) else begin
          n_errors++;
          $error("FAIL sb_unexpected: observed out_valid=1 expected no pending result");
        end
        if (q.size() > 0) begin
          x = q.pop_front();
          check("sb_res", {16'd0, ALURes}, {16'd0, x.res});
          check("sb_tgt", {16'd0, targetPC}, {16'd0, x.tgt});
          check("sb_redirect", {31'd0, redirect}, {31'd0, x.rd});
          check("sb_err", {31'd0, err}, {31'd0, x.e});
        end
      end
      if (in_valid && in_ready && !rst) begin
        q.push_back(model());
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    in_valid = 0; readdata1 = 0; readdata2 = 0; immediate = 0; PC = 0; nextPC = 0;
    ALUOp = 0; BranchOp = 0; ALUSrc = 0; invSrc1 = 0; invSrc2 = 0; sub = 0;
    jump = 0; jumpReg = 0; branch = 0; flush = 0;
  endtask

  logic [3:0] op_tbl [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hF, 4'hA};
  logic       seen_valid;

  initial begin
    n_checks = 0;
    n_errors = 0;
    accepted = 0;
    clr();
    out_ready = 1;
    rst = 1;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_alures", {16'd0, ALURes}, 0);
    check("rst_target", {16'd0, targetPC}, 0);
    check("rst_redirect", {31'd0, redirect}, 0);
    check("rst_err", {31'd0, err}, 0);
    rst = 0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 1);

    // ADD
    readdata1 = 16'h0005; immediate = 16'h0003; ALUSrc = 0; ALUOp = 4'h0;
    PC = 16'h0200; nextPC = 16'h0202; in_valid = 1;
    tick();
    clr();
    check("add_valid", {31'd0, out_valid}, 1);
    check("add_res", {16'd0, ALURes}, 32'h0008);
    check("add_err", {31'd0, err}, 0);
    check("add_redirect", {31'd0, redirect}, 0);
    check("add_target", {16'd0, targetPC}, 32'h0202);

    // Signed overflow
    readdata1 = 16'h7FFF; immediate = 16'h0001; ALUOp = 4'h8; nextPC = 16'h0204; in_valid = 1;
    tick();
    clr();
    check("ovf_res", {16'd0, ALURes}, 32'h8000);
    check("ovf_err", {31'd0, err}, 1);

    // Taken branch on equality
    readdata1 = 16'h1234; readdata2 = 16'h1234; ALUSrc = 1; sub = 1; invSrc2 = 1;
    ALUOp = 4'h0; branch = 1; BranchOp = 2'b00; PC = 16'h0100; immediate = 16'h0010;
    nextPC = 16'h0102; in_valid = 1;
    tick();
    clr();
    check("br_redirect", {31'd0, redirect}, 1);
    check("br_target", {16'd0, targetPC}, 32'h0110);
    check("br_res", {16'd0, ALURes}, 0);
    tick();

    // Backpressure: three back-to-back ops, out_ready low for 3 cycles
    out_ready = 0;
    readdata1 = 16'h00F0; immediate = 16'h0F0F; ALUOp = 4'h2; in_valid = 1;
    tick();
    check("bp_first_accept", {31'd0, accepted}, 1);
    readdata1 = 16'h00FF; immediate = 16'h0F0F; ALUOp = 4'h3;
    for (int k = 0; k < 3; k++) begin
      check("bp_in_ready", {31'd0, in_ready}, 0);
      check("bp_hold_valid", {31'd0, out_valid}, 1);
      check("bp_hold_res", {16'd0, ALURes}, 32'h0FFF);
      tick();
    end
    out_ready = 1;
    tick();
    check("bp_reload_valid", {31'd0, out_valid}, 1);
    check("bp_second_res", {16'd0, ALURes}, 32'h0FF0);
    readdata1 = 16'h0001; immediate = 16'h0004; ALUOp = 4'h4;
    tick();
    check("bp_third_res", {16'd0, ALURes}, 32'h0010);
    clr();
    tick();

    // MUL (or illegal opcode when the multiplier is not built)
    readdata1 = 16'h0012; readdata2 = 16'h0034; ALUSrc = 1; ALUOp = 4'hF;
    nextPC = 16'h0300; in_valid = 1;
    tick();
    clr();
`ifdef EXECUTE_PIPE_MUL_EN
    for (int k = 0; k < 16; k++) begin
      check("mul_busy_valid", {31'd0, out_valid}, 0);
      check("mul_busy_in_ready", {31'd0, in_ready}, 0);
      tick();
    end
    check("mul_done_valid", {31'd0, out_valid}, 1);
    check("mul_res", {16'd0, ALURes}, 32'h03A8);
    check("mul_err", {31'd0, err}, 0);
`else
    check("mul_off_valid", {31'd0, out_valid}, 1);
    check("mul_off_res", {16'd0, ALURes}, 0);
    check("mul_off_err", {31'd0, err}, 1);
`endif
    tick();

`ifdef EXECUTE_PIPE_MUL_EN
    // Flush mid-MUL
    readdata1 = 16'h0003; readdata2 = 16'h0007; ALUSrc = 1; ALUOp = 4'hF; in_valid = 1;
    tick();
    clr();
    for (int k = 0; k < 4; k++) tick();
    flush = 1;
    check("mflush_busy", {31'd0, in_ready}, 0);
    tick();
    flush = 0;
    check("mflush_valid", {31'd0, out_valid}, 0);
    check("mflush_in_ready", {31'd0, in_ready}, 1);
    seen_valid = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) seen_valid = 1;
      tick();
    end
    check("mflush_no_result", {31'd0, seen_valid}, 0);
    readdata1 = 16'h0010; immediate = 16'h0020; ALUOp = 4'h0; nextPC = 16'h0400; in_valid = 1;
    tick();
    clr();
    check("mflush_add_valid", {31'd0, out_valid}, 1);
    check("mflush_add_res", {16'd0, ALURes}, 32'h0030);
    tick();
`endif

    // Flush drops a held result and any bundle offered with it
    out_ready = 0;
    readdata1 = 16'h0002; immediate = 16'h0002; ALUOp = 4'h0; in_valid = 1;
    tick();
    check("fl_held_valid", {31'd0, out_valid}, 1);
    readdata1 = 16'h0009; flush = 1;
    check("fl_in_ready_blocked", {31'd0, in_ready}, 0);
    tick();
    flush = 0; in_valid = 0;
    check("fl_cleared", {31'd0, out_valid}, 0);
    out_ready = 1; flush = 1; in_valid = 1;
    check("fl_in_ready_open", {31'd0, in_ready}, 1);
    tick();
    clr();
    check("fl_dropped", {31'd0, out_valid}, 0);

    // Randomised mix with random backpressure, checked by the scoreboard
    for (int n = 0; n < 60; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      readdata1 = 16'($urandom);
      readdata2 = 16'($urandom);
      immediate = 16'($urandom);
      PC        = 16'($urandom);
      nextPC    = 16'($urandom);
      ALUOp     = op_tbl[$urandom_range(0, 10)];
      BranchOp  = 2'($urandom);
      ALUSrc    = 1'($urandom);
      invSrc1   = 1'($urandom);
      invSrc2   = 1'($urandom);
      sub       = 1'($urandom);
      jump      = ($urandom_range(0, 5) == 0);
      jumpReg   = ($urandom_range(0, 5) == 0);
      branch    = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    clr();
    out_ready = 1;
    for (int k = 0; k < 60 && (out_valid || q.size() > 0); k++) tick();
    check("drain_valid", {31'd0, out_valid}, 0);
    check("drain_queue", q.size(), 0);

    // Asynchronous reset takes effect without a clock edge
    out_ready = 0;
    readdata1 = 16'h0001; immediate = 16'h0001; ALUOp = 4'h0; in_valid = 1;
    tick();
    clr();
    check("arst_pre_valid", {31'd0, out_valid}, 1);
    #2;
    rst = 1;
    #1;
    check("arst_valid", {31'd0, out_valid}, 0);
    check("arst_res", {16'd0, ALURes}, 0);
    q.delete();
    tick();
    rst = 0;
    out_ready = 1;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/execute_pipe.md
# execute_pipe

Parametrised, registered successor to the single-cycle execute stage. It evaluates the ALU operation, resolves branches and jumps, and computes the redirect target. Results are held in an output register with a valid/ready handshake, and an optional iterative multiplier runs as a multi-cycle operation. It sits between decode and memory and can stall decode through `in_ready`.

## Interface
- `WIDTH`, default 16: datapath width; all data, immediate and PC ports use it.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand bundle valid.
- `in_ready` out 1: stage can accept a bundle this cycle.
- `readdata1`, `readdata2`, `immediate`, `PC`, `nextPC` in WIDTH: operands, current PC, fall-through PC.
- `ALUOp` in 4, `BranchOp` in 2: operation and branch-condition select.
- `ALUSrc`, `invSrc1`, `invSrc2`, `sub`, `jump`, `jumpReg`, `branch` in 1: control bits.
- `flush` in 1: squash in-flight and held work.
- `out_valid` out 1, `out_ready` in 1: result handshake.
- `ALURes`, `targetPC` out WIDTH: result and next PC.
- `redirect` out 1: control transfer taken.
- `err` out 1: overflow or illegal op.

## Operation
- Operand A' = `invSrc1` ? ~`readdata1` : `readdata1`.
- B = `ALUSrc` ? `readdata2` : `immediate`; B' = `invSrc2` ? ~B : B.
- ALUOp encoding:
  - 0000: A'+B'+`sub`, unsigned.
  - 0001: AND. 0010: OR. 0011: XOR.
  - 0100: SLL by B[3:0]. 0101: SRL. 0110: SRA. 0111: ROL.
  - 1000: A'+B'+`sub`, signed; `err` on two's-complement overflow.
  - 1111: MUL, giving low WIDTH bits of `readdata1`*B.
  - Any other opcode gives `ALURes`=0 and `err`=1.
- Branch condition on the ALU result R:
  - 00: R==0. 01: R!=0. 10: R[WIDTH-1]=1. 11: R[WIDTH-1]=0.
- `redirect` = `jump` | `jumpReg` | (`branch` & condition).
- Target base = `jumpReg` ? `readdata1` : `PC`; `targetPC` = `redirect` ? base+`immediate` : `nextPC`.
- `err` is also set on signed overflow of the target add, but only when `redirect`=1.
- FSM:
  - IDLE → MUL when a MUL op is accepted.
  - MUL → IDLE when the counter reaches 0 and the output register loads.
  - Any state → IDLE on `flush`.
- `in_ready` = (state==IDLE) & (~`out_valid` | `out_ready`).
- Multiplier: shift-add over WIDTH iterations with a down-counter from WIDTH-1. Operands are latched at acceptance. MUL never sets `err`.
- `flush` has priority:
  - Clears `out_valid`, aborts any MUL and returns to IDLE.
  - A bundle offered in the same cycle is dropped.
  - `in_ready` still reads 1 in that cycle if the formula allows, but nothing is captured.

## Timing
- Reset values:
  - `out_valid`=0; `ALURes`, `targetPC`, `redirect`, `err` all 0; state IDLE; counter 0.
  - `in_ready`=1 after reset deasserts.
- Non-MUL op accepted at edge T: outputs valid after edge T, `out_valid`=1 from cycle T+1.
- Throughput is 1 per cycle while `out_ready`=1.
- MUL accepted at T: `out_valid`=1 in cycle T+WIDTH+1, with `in_ready`=0 until then.
- While `out_valid` & ~`out_ready`, all outputs hold stable and no bundle is accepted.
- Simultaneous drain and accept (`out_valid` & `out_ready` & `in_valid` in IDLE): the register reloads, so `out_valid` stays 1.
- `rst` asserted mid-MUL: immediately returns to reset values with no edge needed.

## Configuration
- `EXECUTE_PIPE_MUL_EN`:
  - Defined: MUL state, counter and shift-add datapath are built.
  - Undefined: ALUOp 1111 is illegal (`ALURes`=0, `err`=1, single-cycle) and the FSM stays in IDLE.

## Test plan
- ADD: `readdata1`=0x0005, `immediate`=0x0003, `ALUSrc`=0, ALUOp=0000 → next cycle `ALURes`=0x0008, `err`=0, `redirect`=0, `targetPC`=`nextPC`.
- Signed overflow: A=0x7FFF, B=0x0001, ALUOp=1000 → `ALURes`=0x8000, `err`=1.
- Branch: `branch`=1, BranchOp=00, A=B=0x1234, `sub`=1, `invSrc2`=1, ALUOp=0000, `PC`=0x0100, `immediate`=0x0010 → `redirect`=1, `targetPC`=0x0110.
- Backpressure: three back-to-back ops with `out_ready`=0 for 3 cycles → first result held stable, `in_ready`=0, remaining results delivered in order once `out_ready`=1.
- MUL (macro on): 0x0012 × 0x0034 → `ALURes`=0x03A8 at T+17, `in_ready`=0 throughout.
  - Same op with macro off → `err`=1 at T+1.
- Flush mid-MUL at T+5 → `out_valid` stays 0, state IDLE, `in_ready`=1 at T+6; a following ADD completes normally.
